// File: rtl/vga_timing_pkg.sv
// Video mode constants and total-size helper for the timing generator.
// Pure constants: no logic, no latency.
package vga_timing_pkg;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hsync_pol;
    logic vsync_pol;
  } mode_t;

  localparam mode_t MODE_640X480 = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                     v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                                     hsync_pol: 1'b0, vsync_pol: 1'b0};

  localparam mode_t MODE_800X600 = '{h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
                                     v_active: 600, v_fp: 37, v_sync: 6, v_bp: 23,
                                     hsync_pol: 1'b1, vsync_pol: 1'b1};

  // Tiny mode so a whole frame (14 x 7) fits in a short simulation.
  localparam mode_t MODE_SIM = '{h_active: 8, h_fp: 2, h_sync: 2, h_bp: 2,
                                 v_active: 4, v_fp: 1, v_sync: 1, v_bp: 1,
                                 hsync_pol: 1'b0, vsync_pol: 1'b0};

  function automatic int mode_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pos_counter.sv
// Wrapping x/y position counter advancing on ce; exposes next-state and registered position.
// Latency 1 clock; ce=0 holds the position.
module vga_pos_counter #(
  parameter int CW      = 12,
  parameter int X_TOTAL = 800,
  parameter int Y_TOTAL = 525,
  parameter int X_START = 0,
  parameter int Y_START = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [CW-1:0] x_q,
  output logic [CW-1:0] y_q,
  output logic [CW-1:0] x_d,
  output logic [CW-1:0] y_d
);

  localparam logic [CW-1:0] X_LAST = CW'(X_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(Y_TOTAL - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ce) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= CW'(X_START);
      y_q <= CW'(Y_START);
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: beam counters, syncs, strobes and a look-ahead fetch position.
// All outputs registered, 1 clock after a pix_ce edge; pix_ce=0 freezes every output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = MODE_640X480.h_active,
  parameter int   H_FP      = MODE_640X480.h_fp,
  parameter int   H_SYNC    = MODE_640X480.h_sync,
  parameter int   H_BP      = MODE_640X480.h_bp,
  parameter int   V_ACTIVE  = MODE_640X480.v_active,
  parameter int   V_FP      = MODE_640X480.v_fp,
  parameter int   V_SYNC    = MODE_640X480.v_sync,
  parameter int   V_BP      = MODE_640X480.v_bp,
  parameter logic HSYNC_POL = MODE_640X480.hsync_pol,
  parameter logic VSYNC_POL = MODE_640X480.vsync_pol,
  parameter int   PREFETCH  = 2,
  parameter int   CW        = 12
) (
  input  logic          clk_25mhz,
  input  logic          resetn,
  input  logic          pix_ce,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_valid,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid
);

  localparam int H_TOTAL = mode_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = mode_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] HA    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_LO = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] beam_x_q, beam_y_q, beam_x_d, beam_y_d;
  logic [CW-1:0] fetch_x_q, fetch_y_q, fetch_x_d, fetch_y_d;

  vga_pos_counter #(
    .CW(CW), .X_TOTAL(H_TOTAL), .Y_TOTAL(V_TOTAL), .X_START(0), .Y_START(0)
  ) u_beam (
    .clk(clk_25mhz), .rst_n(resetn), .ce(pix_ce),
    .x_q(beam_x_q), .y_q(beam_y_q), .x_d(beam_x_d), .y_d(beam_y_d)
  );

  // Same counter started PREFETCH pixels ahead; it wraps lines/frames on its own.
  vga_pos_counter #(
    .CW(CW), .X_TOTAL(H_TOTAL), .Y_TOTAL(V_TOTAL), .X_START(PREFETCH), .Y_START(0)
  ) u_fetch (
    .clk(clk_25mhz), .rst_n(resetn), .ce(pix_ce),
    .x_q(fetch_x_q), .y_q(fetch_y_q), .x_d(fetch_x_d), .y_d(fetch_y_d)
  );

  logic hsync_d, vsync_d, display_valid_d, line_start_d, frame_start_d, fetch_valid_d;
  logic hsync_q, vsync_q, display_valid_q, line_start_q, frame_start_q, fetch_valid_q;

  // Decoding the next position keeps the registered flags aligned with hpos/vpos.
  always_comb begin
    hsync_d         = ((beam_x_d >= HS_LO) && (beam_x_d < HS_HI)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d         = ((beam_y_d >= VS_LO) && (beam_y_d < VS_HI)) ? VSYNC_POL : ~VSYNC_POL;
    display_valid_d = (beam_x_d < HA) && (beam_y_d < VA);
    line_start_d    = (beam_x_d == '0);
    frame_start_d   = (beam_x_d == '0) && (beam_y_d == '0);
    fetch_valid_d   = (fetch_x_d < HA) && (fetch_y_d < VA);
  end

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      hsync_q         <= ~HSYNC_POL;
      vsync_q         <= ~VSYNC_POL;
      display_valid_q <= 1'b1;
      line_start_q    <= 1'b1;
      frame_start_q   <= 1'b1;
      fetch_valid_q   <= (PREFETCH < H_ACTIVE);
    end else begin
      hsync_q         <= hsync_d;
      vsync_q         <= vsync_d;
      display_valid_q <= display_valid_d;
      line_start_q    <= line_start_d;
      frame_start_q   <= frame_start_d;
      fetch_valid_q   <= fetch_valid_d;
    end
  end

  assign hpos          = beam_x_q;
  assign vpos          = beam_y_q;
  assign fetch_x       = fetch_x_q;
  assign fetch_y       = fetch_y_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign display_valid = display_valid_q;
  assign line_start    = line_start_q;
  assign frame_start   = frame_start_q;
  assign fetch_valid   = fetch_valid_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three generator configurations driven by a shared random pix_ce, compared each
// clock against a pixel-count reference model.
module tb_vga_timing_gen;

  logic clk_25mhz = 1'b0;
  logic resetn    = 1'b0;
  logic pix_ce    = 1'b0;

  always #5 clk_25mhz = ~clk_25mhz;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;  // pixel periods elapsed since reset

  typedef struct {
    int hpos, vpos, fx, fy;
    int hs, vs, dv, ls, fs, fv;
  } exp_t;

  // DUT A: sim mode, active-low syncs, PREFETCH 3
  logic [11:0] a_hpos, a_vpos, a_fx, a_fy;
  logic        a_hs, a_vs, a_dv, a_ls, a_fs, a_fv;
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PREFETCH(3), .CW(12)
  ) dut_a (
    .clk_25mhz(clk_25mhz), .resetn(resetn), .pix_ce(pix_ce),
    .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hs), .vsync(a_vs),
    .display_valid(a_dv), .line_start(a_ls), .frame_start(a_fs),
    .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
  );

  // DUT B: sim mode, active-high syncs, maximum PREFETCH (H_TOTAL-1)
  logic [11:0] b_hpos, b_vpos, b_fx, b_fy;
  logic        b_hs, b_vs, b_dv, b_ls, b_fs, b_fv;
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PREFETCH(13), .CW(12)
  ) dut_b (
    .clk_25mhz(clk_25mhz), .resetn(resetn), .pix_ce(pix_ce),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hs), .vsync(b_vs),
    .display_valid(b_dv), .line_start(b_ls), .frame_start(b_fs),
    .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
  );

  // DUT C: default 640x480 mode
  logic [11:0] c_hpos, c_vpos, c_fx, c_fy;
  logic        c_hs, c_vs, c_dv, c_ls, c_fs, c_fv;
  vga_timing_gen dut_c (
    .clk_25mhz(clk_25mhz), .resetn(resetn), .pix_ce(pix_ce),
    .hpos(c_hpos), .vpos(c_vpos), .hsync(c_hs), .vsync(c_vs),
    .display_valid(c_dv), .line_start(c_ls), .frame_start(c_fs),
    .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv)
  );

  function automatic exp_t model(input int cnt, input int ha, input int hf, input int hsw,
                                 input int hb, input int va, input int vf, input int vsw,
                                 input int vb, input int hp, input int vp, input int pf);
    exp_t m;
    int ht, vt, f;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    m.hpos = cnt % ht;
    m.vpos = (cnt / ht) % vt;
    f      = cnt + pf;
    m.fx   = f % ht;
    m.fy   = (f / ht) % vt;
    m.hs   = (m.hpos >= ha + hf && m.hpos < ha + hf + hsw) ? hp : 1 - hp;
    m.vs   = (m.vpos >= va + vf && m.vpos < va + vf + vsw) ? vp : 1 - vp;
    m.dv   = (m.hpos < ha && m.vpos < va) ? 1 : 0;
    m.ls   = (m.hpos == 0) ? 1 : 0;
    m.fs   = (m.hpos == 0 && m.vpos == 0) ? 1 : 0;
    m.fv   = (m.fx < ha && m.fy < va) ? 1 : 0;
    return m;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t, n=%0d)", tag, obs, exp, $time, n);
    end
  endtask

  task automatic check_dut(input string nm, input exp_t e,
                           input int hp, input int vp, input int fx, input int fy,
                           input int hs, input int vs, input int dv, input int ls,
                           input int fs, input int fv);
    check({nm, ".hpos"}, hp, e.hpos);
    check({nm, ".vpos"}, vp, e.vpos);
    check({nm, ".fetch_x"}, fx, e.fx);
    check({nm, ".fetch_y"}, fy, e.fy);
    check({nm, ".hsync"}, hs, e.hs);
    check({nm, ".vsync"}, vs, e.vs);
    check({nm, ".display_valid"}, dv, e.dv);
    check({nm, ".line_start"}, ls, e.ls);
    check({nm, ".frame_start"}, fs, e.fs);
    check({nm, ".fetch_valid"}, fv, e.fv);
  endtask

  task automatic check_all();
    check_dut("a", model(n, 8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 3),
              a_hpos, a_vpos, a_fx, a_fy, a_hs, a_vs, a_dv, a_ls, a_fs, a_fv);
    check_dut("b", model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 13),
              b_hpos, b_vpos, b_fx, b_fy, b_hs, b_vs, b_dv, b_ls, b_fs, b_fv);
    check_dut("c", model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2),
              c_hpos, c_vpos, c_fx, c_fy, c_hs, c_vs, c_dv, c_ls, c_fs, c_fv);
  endtask

  task automatic step(input bit ce);
    pix_ce = ce;
    @(posedge clk_25mhz);
    #1;
    if (ce && resetn) n++;
    check_all();
  endtask

  initial begin
    int cnt_dv, cnt_fs, cnt_hs, cnt_vs, cnt_bhs, cnt_bvs, cnt_ls;
    int h0, v0;

    // Reset state
    repeat (2) @(posedge clk_25mhz);
    #1;
    check_all();
    resetn = 1'b1;
    step(1'b0);

    // One full sim-mode frame at full rate, with per-frame tallies
    cnt_dv = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; cnt_bhs = 0; cnt_bvs = 0;
    for (int i = 0; i < 98; i++) begin
      step(1'b1);
      cnt_dv  += int'(a_dv);
      cnt_fs  += int'(a_fs);
      cnt_hs  += int'(!a_hs);
      cnt_vs  += int'(!a_vs);
      cnt_bhs += int'(b_hs);
      cnt_bvs += int'(b_vs);
    end
    check("frame_dv_count", cnt_dv, 32);
    check("frame_fs_count", cnt_fs, 1);
    check("frame_hsync_low_count", cnt_hs, 14);
    check("frame_vsync_low_count", cnt_vs, 14);
    check("frame_b_hsync_high_count", cnt_bhs, 14);
    check("frame_b_vsync_high_count", cnt_bvs, 14);
    for (int i = 0; i < 98; i++) step(1'b1);

    // Rate /3: pattern 1-0-0, a sim line takes 42 clocks
    h0 = int'(a_hpos);
    v0 = int'(a_vpos);
    cnt_ls = 0;
    for (int i = 0; i < 42; i++) begin
      step(i % 3 == 0);
      cnt_ls += int'(a_ls);
    end
    check("div3_hpos_after_line", int'(a_hpos), h0);
    check("div3_vpos_after_line", int'(a_vpos), (v0 + 1) % 7);
    check("div3_line_start_clocks", cnt_ls, 3);

    // Random pix_ce; long enough for the 640x480 instance to cross its hsync region
    for (int i = 0; i < 2600; i++) step($urandom_range(0, 3) != 0);

    // Mid-frame asynchronous reset at sim position (5,2)
    for (int i = 0; i < 100 && (n % 98) != 33; i++) step(1'b1);
    check("pre_reset_hpos", int'(a_hpos), 5);
    check("pre_reset_vpos", int'(a_vpos), 2);
    #2;
    resetn = 1'b0;
    n = 0;
    #1;
    check_all();
    @(posedge clk_25mhz);
    #1;
    check_all();
    resetn = 1'b1;
    step(1'b1);
    check("post_reset_first_ce_hpos", int'(a_hpos), 1);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 1) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
